// File: rtl/irq_pending_latch_pkg.sv
// Shared constants and types for the interrupt pending latch and its encoder hookup.
// Optional IRQ_LEVEL_EN selects level-sensitive requests; default is edge mode.
package irq_pkg;

    localparam int IRQ_N     = 16;
    localparam int IRQ_IDX_W = 4;

    typedef logic [IRQ_N-1:0]     irq_vec_t;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        SERVICE
    } irq_state_t;

    function automatic irq_vec_t irq_onehot(input irq_idx_t idx);
        irq_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request, encoder and valid/ack/eoi handshake signals of the interrupt pending latch.
// The slave modport is the latch itself; master is the surrounding parent.
interface irq_pending_latch_if;
    import irq_pkg::*;

    irq_vec_t req_in;
    irq_vec_t mask;
    irq_vec_t pend_out;
    irq_idx_t enc_y;
    logic     irq_valid;
    irq_idx_t irq_id;
    logic     irq_ack;
    logic     irq_eoi;
    logic     in_service;

    modport master (
        output req_in, mask, enc_y, irq_ack, irq_eoi,
        input  pend_out, irq_valid, irq_id, in_service
    );

    modport slave (
        input  req_in, mask, enc_y, irq_ack, irq_eoi,
        output pend_out, irq_valid, irq_id, in_service
    );

endinterface

// File: rtl/irq_pending_latch_edge_det.sv
// Rising-edge detector for the request lines; becomes a wire when IRQ_LEVEL_EN is defined.
module irq_edge_det
    import irq_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  irq_vec_t req_i,
    output irq_vec_t edge_o
);

`ifdef IRQ_LEVEL_EN
    assign edge_o = req_i;
`else
    irq_vec_t req_q;

    // req_q resets low so a request already high at reset release counts as an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end

    assign edge_o = req_i & ~req_q;
`endif

endmodule

// File: rtl/irq_pending_latch.sv
// Interrupt pending latch: latches request edges, feeds an external priority encoder,
// and services one interrupt at a time. IRQ_LEVEL_EN selects level mode.
module irq_pending_latch
    import irq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    irq_pending_latch_if.slave  bus
);

    irq_vec_t   req_edge;
    irq_vec_t   pending_q;
    irq_vec_t   pending_d;
    irq_vec_t   pend_out_q;
    irq_state_t state_q;
    irq_state_t state_d;
    logic       irq_valid_q;
    logic       irq_valid_d;
    logic       in_service_q;
    logic       in_service_d;
    irq_idx_t   irq_id_q;
    irq_idx_t   irq_id_d;

    irq_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (bus.req_in),
        .edge_o (req_edge)
    );

`ifdef IRQ_LEVEL_EN
    assign pending_d = req_edge;
`else
    irq_vec_t clr;

    // A fresh edge ORed in after the clear lets a new request win over the ack
    assign clr       = (state_q == PRESENT && bus.irq_ack) ? irq_onehot(irq_id_q) : '0;
    assign pending_d = (pending_q & ~clr) | req_edge;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q    <= '0;
            pend_out_q   <= '0;
            state_q      <= IDLE;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            pend_out_q   <= pending_d & ~bus.mask;
            state_q      <= state_d;
            irq_valid_q  <= irq_valid_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    // Once presented, the ID is held even if its line is masked afterwards
    always_comb begin
        state_d      = state_q;
        irq_valid_d  = irq_valid_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        unique case (state_q)
            IDLE: begin
                if (pend_out_q != '0) begin
                    irq_id_d    = bus.enc_y;
                    irq_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.irq_ack) begin
                    irq_valid_d  = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.irq_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pend_out   = pend_out_q;
    assign bus.irq_valid  = irq_valid_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.in_service = in_service_q;

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Interrupt request front-end directly upstream of the 16-to-4 priority encoder `pencode_if`. It detects rising edges on 16 request lines and holds them in a pending register. It drives the masked pending vector into the encoder's `d_in` and registers the encoder's `y` back as the interrupt ID. A valid/ack/end-of-interrupt handshake then services one interrupt at a time.

## Interface
- `N`, 16, number of request lines; must equal encoder input width
- `IDX_W`, 4, ID width; log2(N)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_in`  in  N  request lines, synchronous to `clk`
- `mask`  in  N  1 = line masked (still latched, not presented)
- `pend_out`  out  N  registered `pending & ~mask`; wired to encoder `d_in`
- `enc_y`  in  IDX_W  encoder output `y`; combinational function of `pend_out`
- `irq_valid`  out  1  interrupt presented
- `irq_id`  out  IDX_W  ID of presented interrupt; stable while `irq_valid`
- `irq_ack`  in  1  consumer accepts presented ID
- `irq_eoi`  in  1  end-of-interrupt pulse for in-service ID
- `in_service`  out  1  high from ack until eoi

## Operation
- Edge detect: `req_q <= req_in` each cycle; `edge = req_in & ~req_q`.
- Pending update, per bit: `pending_nxt = (pending & ~clr) | edge`. `clr` is the one-hot of `irq_id` on an accepted ack.
- Set wins: edge and clear on the same bit in the same cycle leave the bit set.
- `pend_out <= pending_nxt & ~mask`.
- FSM states: IDLE, PRESENT, SERVICE.
- IDLE: if `pend_out != 0`, register `irq_id <= enc_y`, `irq_valid <= 1`, go to PRESENT. Otherwise stay in IDLE.
- PRESENT: hold `irq_valid` and `irq_id`.
  - On `irq_ack`: clear `pending[irq_id]`, drop `irq_valid`, set `in_service`, go to SERVICE.
  - A later mask of the presented bit does not withdraw the presentation.
- SERVICE: on `irq_eoi`, drop `in_service` and go to IDLE. New edges keep latching meanwhile.
- Ignored inputs: `irq_ack` outside PRESENT; `irq_eoi` outside SERVICE.
- Priority: whatever `enc_y` reports. With `pencode_if`, the highest set bit of `pend_out` wins.
- Reset values: `req_q`=0, `pending`=0, `pend_out`=0, `irq_valid`=0, `irq_id`=0, `in_service`=0, FSM=IDLE.
- Because `req_q` resets to 0, a request held high at reset release is latched on the first post-reset edge.
- Reset asserted in any state clears everything at the next edge, with no completion of the handshake.

## Timing
- Request latency: `req_in` rises before edge E0. At E0, `pending` and `pend_out` are set. At E1, `irq_valid`=1 with `irq_id` = `enc_y` sampled at E1. Total latency is two edges.
- Mask change reaches `pend_out` after one edge.
- Ack at edge Ea: `irq_valid`=0 and `in_service`=1 after Ea. The cleared bit leaves `pend_out` after Ea.
- EOI at edge Ee: FSM is in IDLE after Ee. If other bits are pending, the next `irq_valid` rises at Ee+1.
- Back-to-back throughput: at most one interrupt per 3 cycles (present, ack, eoi).

## Configuration
- `IRQ_LEVEL_EN` defined: level mode.
  - Edge detect is bypassed: `pending <= req_in`.
  - Ack does not clear `pending`; the source must drop its request.
  - All other behaviour is unchanged.
- `IRQ_LEVEL_EN` undefined (default): edge mode as described above.

## Structure
- Package `irq_pkg` holds:
  - constants `IRQ_N`=16 and `IRQ_IDX_W`=4;
  - typedef `irq_state_t` (IDLE, PRESENT, SERVICE);
  - typedef `irq_vec_t` (logic [IRQ_N-1:0]).
- One sub-module, `irq_edge_det`, contains `req_q` and the N-bit edge vector. It is compiled transparent under `IRQ_LEVEL_EN`.
- The encoder is not instantiated inside this block. The parent wires `pend_out` to `d_in` and `y` to `enc_y`; the bench does the same with `pencode_if`.

## Test plan
- Single edge: `req_in`=0x0001 for 1 cycle, then ack, then eoi. Expect `irq_valid` 2 edges later with `irq_id`=0; `pend_out` 0x0001 then 0x0000; `in_service` spans ack to eoi.
- Priority: `req_in`=0x600A in one cycle. Expect IDs 14, 13, 3, 1 in that order across four ack/eoi rounds; `pend_out` goes 0x600A, 0x200A, 0x000A, 0x0002, 0x0000.
- Mask: `mask`=0x8000 with edge on bit 15. Expect `pend_out`=0 and no `irq_valid`. Then `mask`=0: `irq_id`=15 two edges later.
- Set-wins: bit 3 presented; a new edge on bit 3 arrives in the ack cycle. Expect `pending[3]` still 1 and `irq_id`=3 re-presented after eoi.
- Ignored inputs and reset: `irq_eoi` in IDLE and `irq_ack` in SERVICE cause no state change. `rst_n`=0 during PRESENT forces all outputs to 0 and FSM to IDLE at the next edge.
- `IRQ_LEVEL_EN`: hold `req_in`=0x0010 through ack and eoi. Expect `irq_id`=4 re-presented until `req_in` drops.
